// File: rtl/core_pkg.sv
// Shared definitions for the program loader: loader states, default widths
// and the instruction memory depth.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } load_state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_W_DEF = 16;
  localparam int IMEM_DEPTH = 256;

endpackage

// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles 16-bit words from a framed byte stream,
// writes them to instruction memory from address 0, verifies an XOR checksum.
module prog_loader
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              load_err
);

  load_state_e       r_state;
  load_state_e       w_next;
  logic [7:0]        r_cnt;
  logic [7:0]        r_hi;
  logic [7:0]        r_xor;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_core_run;
  logic              r_load_err;
  logic              w_accept;
  logic              w_chk_ok;

  // Ready is combinational on reload so an abort never swallows a byte.
  assign byte_ready = (r_state inside {ST_IDLE, ST_HI, ST_LO, ST_CHK}) && !reload;
  assign w_accept   = byte_valid && byte_ready;
  assign w_chk_ok   = (byte_in == r_xor);

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_run  = r_core_run;
  assign load_err  = r_load_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; reload overrides everything, illegal codes recover to IDLE.
  always_comb begin
    w_next = r_state;
    if (reload) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = w_accept ? ((byte_in != 8'd0) ? ST_HI : ST_CHK) : ST_IDLE;
        ST_HI:   w_next = w_accept ? ST_LO : ST_HI;
        ST_LO:   w_next = w_accept ? ((r_cnt == 8'd1) ? ST_CHK : ST_HI) : ST_LO;
        ST_CHK:  w_next = w_accept ? (w_chk_ok ? ST_DONE : ST_ERR) : ST_CHK;
        ST_DONE: w_next = ST_DONE;
        ST_ERR:  w_next = ST_ERR;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered memory/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_hi        <= 8'd0;
      r_xor       <= 8'd0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_run  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (reload) begin
        r_cnt      <= 8'd0;
        r_hi       <= 8'd0;
        r_xor      <= 8'd0;
        r_core_run <= 1'b0;
        r_load_err <= 1'b0;
      end else if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            r_cnt  <= byte_in;
            r_addr <= '0;
            r_xor  <= byte_in;
          end
          ST_HI: begin
            r_hi  <= byte_in;
            r_xor <= r_xor ^ byte_in;
          end
          ST_LO: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= WORD_W'({r_hi, byte_in});
            r_addr      <= r_addr + ADDR_W'(1);
            r_cnt       <= r_cnt - 8'd1;
            r_xor       <= r_xor ^ byte_in;
          end
          ST_CHK: begin
            r_core_run <= w_chk_ok;
            r_load_err <= !w_chk_ok;
          end
          default: begin
            r_cnt <= r_cnt;
          end
        endcase
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader placed directly upstream of the processor core's instruction memory. It receives a framed program image over a valid/ready byte stream, assembles 16-bit instruction words, writes them to consecutive memory addresses from 0, verifies an XOR checksum, then releases the core to run. It replaces the fixed boot-time image load, so programs can be changed without a rebuild.

## Interface
Parameters:
- ADDR_W, 8: instruction memory address width; matches the 8-bit program counter.
- WORD_W, 16: instruction word width; matches the instruction register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reload  in  1  single-cycle request to abort or restart and wait for a new frame.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in holds a byte.
- byte_ready  out  1  loader accepts a byte; the transfer happens when byte_valid and byte_ready are both high.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  WORD_W  write data, first-received byte in bits [15:8].
- core_run  out  1  high: core may execute. Low: core is held.
- load_err  out  1  sticky error flag; checksum mismatch.

## Operation
- Frame layout: LEN byte (N words, 0–255), then 2N data bytes (high byte first per word), then a CHK byte.
- Checksum rule: the CHK byte must equal the XOR of LEN and all 2N data bytes.
- States and transitions:
  - IDLE: accept LEN, load the word counter with N, clear the address to 0, seed the running XOR with LEN. Go to HI if N≠0, else to CHK.
  - HI: accept a byte into hold[15:8], XOR it into the running checksum, go to LO.
  - LO: accept a byte and complete the word. Pulse mem_we next cycle, then increment the address and decrement the counter. Go to CHK if the counter reaches 0, else to HI.
  - CHK: accept a byte. If it matches, go to DONE and set core_run. If not, go to ERR and set load_err.
  - DONE and ERR: byte_ready is low. Both states are held until reload.
- byte_ready = (state ∈ {IDLE, HI, LO, CHK}) && !reload. It may depend combinationally on reload. It must not depend on byte_valid.
- reload: return to IDLE in any state, clear core_run and load_err, and discard a partial word and the running checksum.
  - reload wins over a simultaneous byte_valid; that byte is not accepted.
  - If reload coincides with the LO accept, no write occurs.
- Memory already written by an aborted or failed frame is not scrubbed. core_run stays low, so that content is never executed.
- Address wraps are impossible, because N≤255 keeps the last address ≤254.

## Timing
- Reset values: state IDLE; byte_ready 1 (when reload is low); mem_we 0; mem_addr 0; mem_wdata 0; core_run 0; load_err 0.
- Accepting a byte takes one cycle. Back-to-back bytes are sustained at 1 byte per cycle.
- mem_we, mem_addr and mem_wdata are registered. They are valid for exactly the one cycle following the LO accept.
- core_run and load_err rise the cycle after the CHK accept.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously), including dropping a pending mem_we.

## Structure
- Shared package core_pkg holds:
  - loader state enum: IDLE, HI, LO, CHK, DONE, ERR;
  - ADDR_W and WORD_W defaults;
  - a helper constant for the instruction memory depth (256).
- Single module with no sub-modules. The stream is consumed directly; a UART receiver is a separate, existing-style front end, not part of this block.

## Test plan
- Normal load: rst, then bytes 0x02, 0x40, 0x05, 0x78, 0x00, 0x3F.
  - Required: writes addr0 = 0x4005 and addr1 = 0x7800.
  - core_run = 1 one cycle after 0x3F; load_err = 0.
- Bad checksum: same frame with CHK 0x3E.
  - Required: both writes occur, core_run stays 0, load_err = 1, byte_ready = 0 until reload.
- Empty program: 0x00, 0x00.
  - Required: no mem_we; core_run = 1.
- Backpressure gaps: normal frame with byte_valid toggled low between bytes.
  - Required: identical writes and result; no extra or duplicate writes.
- Reload mid-word: 0x02, 0x40, then reload pulsed together with byte 0x05, then a full normal frame.
  - Required: 0x05 is not accepted; no write from the aborted frame; the new frame loads correctly.
- Reset mid-frame: rst asserted on the LO accept cycle.
  - Required: mem_we stays 0, outputs are at reset values, and the next frame loads from addr 0.
